// File: rtl/icache_fetch_ctrl.sv
// Fetch sequencer: issues one 128-bit line per cycle from the combinational I-cache into the fetch queue.
// Latency: issue in cycle N, queue write in cycle N+1. Backpressure: fq_full stalls issue, and redirect overrides everything.
module icache_fetch_ctrl #(
    parameter logic [31:0] PC_LIMIT = 32'h3FF,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      start_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             fq_full,
    output logic             fq_wr_en,
    output logic [127:0]     fq_wr_data,
    output logic [3:0]       fq_wr_mask,
    output logic [31:0]      fq_wr_pc,
    output logic [31:0]      ic_pc,
    output logic             ic_rd_en,
    output logic             ic_abort,
    input  logic [127:0]     ic_dout,
    input  logic             ic_dout_valid,
    output logic             fault,
    output logic             busy,
    output logic [CNT_W-1:0] line_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic        issue;
    logic        redirect_take;
    logic        pc_over;
    logic [31:0] pc_next_line;

    assign pc_over       = pc_q > PC_LIMIT;
    assign redirect_take = redirect_valid && (state_q != S_IDLE);
    assign issue         = (state_q == S_FETCH) && !redirect_valid && !fq_full && !pc_over;
    assign pc_next_line  = {pc_q[31:4] + 28'd1, 4'h0};

    assign ic_pc    = pc_q;
    assign ic_rd_en = issue;
    assign ic_abort = redirect_take;
    assign busy     = state_q != S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= 32'h0;
            line_cnt   <= '0;
            fq_wr_en   <= 1'b0;
            fq_wr_data <= 128'h0;
            fq_wr_mask <= 4'h0;
            fq_wr_pc   <= 32'h0;
            fault      <= 1'b0;
        end else begin
            fq_wr_en <= 1'b0;
            if (state_q == S_IDLE) begin
                if (redirect_valid) begin
                    pc_q    <= redirect_pc;
                    state_q <= S_FETCH;
                end else if (start) begin
                    pc_q    <= start_pc;
                    state_q <= S_FETCH;
                end
            end else if (redirect_take) begin
                pc_q    <= redirect_pc;
                fault   <= 1'b0;
                state_q <= S_FETCH;
            end else if (state_q == S_FETCH) begin
                if (pc_over) begin
                    fault   <= 1'b1;
                    state_q <= S_FAULT;
                end else if (issue) begin
                    if (ic_dout_valid) begin
                        fq_wr_en   <= 1'b1;
                        fq_wr_data <= ic_dout;
                        fq_wr_pc   <= {pc_q[31:4], 4'h0};
                        // Slots below the entry point of an unaligned target are not valid.
                        fq_wr_mask <= 4'hF << pc_q[3:2];
                        pc_q       <= pc_next_line;
                        if (line_cnt != {CNT_W{1'b1}})
                            line_cnt <= line_cnt + CNT_W'(1);
                    end else begin
                        fault   <= 1'b1;
                        state_q <= S_FAULT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Vector table plus write scoreboard for icache_fetch_ctrl.
module tb_icache_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  start_pc;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         fq_full;
    logic         fq_wr_en;
    logic [127:0] fq_wr_data;
    logic [3:0]   fq_wr_mask;
    logic [31:0]  fq_wr_pc;
    logic [31:0]  ic_pc;
    logic         ic_rd_en;
    logic         ic_abort;
    logic [127:0] ic_dout;
    logic         ic_dout_valid;
    logic         fault;
    logic         busy;
    logic [15:0]  line_cnt;

    always #5 clk = ~clk;

    icache_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fq_full(fq_full),
        .fq_wr_en(fq_wr_en), .fq_wr_data(fq_wr_data), .fq_wr_mask(fq_wr_mask),
        .fq_wr_pc(fq_wr_pc), .ic_pc(ic_pc), .ic_rd_en(ic_rd_en), .ic_abort(ic_abort),
        .ic_dout(ic_dout), .ic_dout_valid(ic_dout_valid), .fault(fault), .busy(busy),
        .line_cnt(line_cnt)
    );

    function automatic logic [127:0] line_of(input logic [31:0] pc);
        return {~pc, pc + 32'd12, pc ^ 32'hA5A5A5A5, pc};
    endfunction

    assign ic_dout = line_of(ic_pc);

    typedef struct {
        logic        st;
        logic [31:0] spc;
        logic        rv;
        logic [31:0] rpc;
        logic        full;
        logic        dv;
        logic        erd;
        logic [31:0] epc;
        logic        eab;
        logic        eflt;
        logic        ebusy;
        int          ecnt;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   mask;
        logic [31:0]  pc;
    } wr_t;

    wr_t  sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic st, input logic [31:0] spc, input logic rv,
                                input logic [31:0] rpc, input logic full, input logic dv,
                                input logic erd, input logic [31:0] epc, input logic eab,
                                input logic eflt, input logic ebusy, input int ecnt);
        vec_t v;
        v.st = st; v.spc = spc; v.rv = rv; v.rpc = rpc; v.full = full; v.dv = dv;
        v.erd = erd; v.epc = epc; v.eab = eab; v.eflt = eflt; v.ebusy = ebusy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare the write pulse of this cycle against whatever the scoreboard owes.
    task automatic check_write(input string tag);
        wr_t w;
        chk({tag, " wr_en"}, {127'h0, fq_wr_en}, {127'h0, sb.size() > 0});
        if (fq_wr_en && sb.size() > 0) begin
            w = sb.pop_front();
            chk({tag, " wr_data"}, fq_wr_data, w.data);
            chk({tag, " wr_mask"}, {124'h0, fq_wr_mask}, {124'h0, w.mask});
            chk({tag, " wr_pc"}, {96'h0, fq_wr_pc}, {96'h0, w.pc});
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        wr_t w;
        @(posedge clk);
        #1;
        start = v.st; start_pc = v.spc; redirect_valid = v.rv; redirect_pc = v.rpc;
        fq_full = v.full; ic_dout_valid = v.dv;
        @(negedge clk);
        check_write(tag);
        chk({tag, " rd_en"}, {127'h0, ic_rd_en}, {127'h0, v.erd});
        chk({tag, " ic_pc"}, {96'h0, ic_pc}, {96'h0, v.epc});
        chk({tag, " abort"}, {127'h0, ic_abort}, {127'h0, v.eab});
        chk({tag, " fault"}, {127'h0, fault}, {127'h0, v.eflt});
        chk({tag, " busy"}, {127'h0, busy}, {127'h0, v.ebusy});
        chk({tag, " line_cnt"}, {112'h0, line_cnt}, 128'(v.ecnt));
        if (v.erd && v.dv) begin
            w.data = line_of(v.epc);
            w.mask = 4'hF << v.epc[3:2];
            w.pc   = {v.epc[31:4], 4'h0};
            sb.push_back(w);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " wr_en"}, {127'h0, fq_wr_en}, 128'h0);
        chk({tag, " wr_data"}, fq_wr_data, 128'h0);
        chk({tag, " wr_mask"}, {124'h0, fq_wr_mask}, 128'h0);
        chk({tag, " wr_pc"}, {96'h0, fq_wr_pc}, 128'h0);
        chk({tag, " fault"}, {127'h0, fault}, 128'h0);
        chk({tag, " busy"}, {127'h0, busy}, 128'h0);
        chk({tag, " rd_en"}, {127'h0, ic_rd_en}, 128'h0);
        chk({tag, " abort"}, {127'h0, ic_abort}, 128'h0);
        chk({tag, " ic_pc"}, {96'h0, ic_pc}, 128'h0);
        chk({tag, " line_cnt"}, {112'h0, line_cnt}, 128'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_pc = 32'h0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; fq_full = 1'b0; ic_dout_valid = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //            st  spc         rv  rpc         full dv  erd epc        eab flt bsy cnt
        // Straight-line stream, redirect to unaligned target, queue stall.
        vecs.push_back(mk(1, 32'h000, 0, 32'h000, 0, 1, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h010, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h020, 0, 0, 1, 2));
        vecs.push_back(mk(0, 32'h000, 1, 32'h108, 0, 1, 0, 32'h030, 1, 0, 1, 3));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h108, 0, 0, 1, 3));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h110, 0, 0, 1, 4));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 1, 1, 0, 32'h120, 0, 0, 1, 5));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 1, 1, 0, 32'h120, 0, 0, 1, 5));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 1, 1, 0, 32'h120, 0, 0, 1, 5));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h120, 0, 0, 1, 5));
        // Run past PC_LIMIT into FAULT, then recover.
        vecs.push_back(mk(0, 32'h000, 1, 32'h3E0, 0, 1, 0, 32'h130, 1, 0, 1, 6));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h3E0, 0, 0, 1, 6));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h3F0, 0, 0, 1, 7));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 0, 32'h400, 0, 0, 1, 8));
        vecs.push_back(mk(1, 32'h700, 0, 32'h000, 0, 1, 0, 32'h400, 0, 1, 1, 8));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 0, 32'h400, 0, 1, 1, 8));
        vecs.push_back(mk(0, 32'h000, 1, 32'h000, 0, 1, 0, 32'h400, 1, 1, 1, 8));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h000, 0, 0, 1, 8));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h010, 0, 0, 1, 9));
        // Invalid cache response at 0x050, start ignored, redirect recovers.
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h020, 0, 0, 1, 10));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h030, 0, 0, 1, 11));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h040, 0, 0, 1, 12));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h050, 0, 0, 1, 13));
        vecs.push_back(mk(1, 32'h700, 0, 32'h000, 0, 1, 0, 32'h050, 0, 1, 1, 13));
        vecs.push_back(mk(1, 32'h700, 0, 32'h000, 0, 1, 0, 32'h050, 0, 1, 1, 13));
        vecs.push_back(mk(0, 32'h000, 1, 32'h204, 0, 1, 0, 32'h050, 1, 1, 1, 13));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h204, 0, 0, 1, 13));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h210, 0, 0, 1, 14));
        // Redirect beats fq_full.
        vecs.push_back(mk(0, 32'h000, 1, 32'h300, 1, 1, 0, 32'h220, 1, 0, 1, 15));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h300, 0, 0, 1, 15));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("v%0d", i));

        // Line 0x300 is in flight: reset must drop it and clear every output at once.
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst_hold");
        rst_n = 1'b1;

        vecs.delete();
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 0, 32'h000, 0, 0, 0, 0));
        // start and redirect together in IDLE: redirect target wins.
        vecs.push_back(mk(1, 32'h500, 1, 32'h00C, 0, 1, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 1, 1, 32'h00C, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 1, 1, 0, 32'h010, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 1, 1, 0, 32'h010, 0, 0, 1, 1));
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("r%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
